// File: rtl/lpm_cam_arbiter_if.sv
// Signal bundle between lpm_cam_arbiter, its lookup/write clients and the CAM.
// slave: the arbiter's view; master: the surrounding clients and CAM.
interface lpm_cam_arbiter_if #(
  parameter int unsigned LUT_DEPTH_BITS = 5
);
  localparam int unsigned ENTRIES = 2 ** LUT_DEPTH_BITS;

  logic                      lookup_req;
  logic [31:0]               lookup_key;
  logic                      lookup_ack;
  logic                      lookup_hit;
  logic [LUT_DEPTH_BITS-1:0] lookup_addr;
  logic                      lookup_fifo_full;
  logic [15:0]               drop_count;

  logic                      wr_req;
  logic [LUT_DEPTH_BITS-1:0] wr_addr;
  logic [31:0]               wr_data;
  logic [31:0]               wr_care;
  logic                      wr_ack;

  logic [31:0]               cam_lookup_data;
  logic [ENTRIES-1:0]        cam_match_lines;
  logic                      cam_match_found;
  logic                      cam_start_write;
  logic [LUT_DEPTH_BITS-1:0] cam_waddr;
  logic [31:0]               cam_wdata;
  logic [31:0]               cam_wcare;
  logic                      cam_ready;

  modport slave (
    input  lookup_req, lookup_key, wr_req, wr_addr, wr_data, wr_care,
           cam_match_lines, cam_match_found, cam_ready,
    output lookup_ack, lookup_hit, lookup_addr, lookup_fifo_full, drop_count,
           wr_ack, cam_lookup_data, cam_start_write, cam_waddr, cam_wdata, cam_wcare
  );

  modport master (
    output lookup_req, lookup_key, wr_req, wr_addr, wr_data, wr_care,
           cam_match_lines, cam_match_found, cam_ready,
    input  lookup_ack, lookup_hit, lookup_addr, lookup_fifo_full, drop_count,
           wr_ack, cam_lookup_data, cam_start_write, cam_waddr, cam_wdata, cam_wcare
  );
endinterface

// File: rtl/lpm_cam_arbiter.sv
// Arbitrates queued longest-prefix lookups and table writes onto a single CAM.
// Lookups are buffered in a small FIFO; contended grants alternate.
module lpm_cam_arbiter #(
  parameter int unsigned LUT_DEPTH_BITS = 5,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset,
  lpm_cam_arbiter_if.slave bus
);
  localparam int unsigned ENTRIES = 2 ** LUT_DEPTH_BITS;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, WR_START, WR_WAIT} state_t;
  typedef enum logic {GNT_LOOKUP, GNT_WRITE} grant_t;

  state_t                    state_q, state_d;
  grant_t                    last_grant_q, last_grant_d;
  logic                      wait_first_q;
  logic                      cap_pend_q;
  logic [31:0]               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic                      fifo_full, lk_pend, pop, push, drop, grant_write;
  logic [LUT_DEPTH_BITS-1:0] match_idx;

  assign fifo_full            = (count_q == CNT_W'(FIFO_DEPTH));
  assign lk_pend              = (count_q != '0);
  assign push                 = bus.lookup_req && (!fifo_full || pop);
  assign drop                 = bus.lookup_req && fifo_full && !pop;
  assign bus.lookup_fifo_full = fifo_full;
  assign bus.cam_start_write  = (state_q == WR_START);
  // wr_ack is decoded inside WR_WAIT, so the ack cycle is never spent in IDLE
  // and a wr_req still held during it cannot start a duplicate write.
  assign bus.wr_ack           = (state_q == WR_WAIT) && !wait_first_q && bus.cam_ready;

  // Next-state and grant decisions.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pop          = 1'b0;
    grant_write  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cam_ready) begin
          if (lk_pend && bus.wr_req) begin
            if (last_grant_q == GNT_WRITE) begin
              pop          = 1'b1;
              last_grant_d = GNT_LOOKUP;
              state_d      = LOOKUP;
            end else begin
              grant_write  = 1'b1;
              last_grant_d = GNT_WRITE;
              state_d      = WR_START;
            end
          end else if (lk_pend) begin
            pop     = 1'b1;
            state_d = LOOKUP;
          end else if (bus.wr_req) begin
            grant_write = 1'b1;
            state_d     = WR_START;
          end
        end
      end
      LOOKUP:   state_d = IDLE;
      WR_START: state_d = WR_WAIT;
      WR_WAIT:  if (!wait_first_q && bus.cam_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register plus the one-cycle phase flags derived from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_WRITE;
      wait_first_q <= 1'b0;
      cap_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_first_q <= (state_q == WR_START);
      // CAM answers one cycle after the key is presented in LOOKUP.
      cap_pend_q   <= (state_q == LOOKUP);
    end
  end

  // Lowest-index matching entry (0 when nothing matches).
  always_comb begin
    match_idx = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (bus.cam_match_lines[i-1]) match_idx = LUT_DEPTH_BITS'(i - 1);
    end
  end

  // Lookup queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Lookup queue storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.lookup_key;
  end

  // Registered outputs: result capture, CAM operands and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.lookup_ack      <= 1'b0;
      bus.lookup_hit      <= 1'b0;
      bus.lookup_addr     <= '0;
      bus.cam_lookup_data <= '0;
      bus.cam_waddr       <= '0;
      bus.cam_wdata       <= '0;
      bus.cam_wcare       <= '0;
      bus.drop_count      <= '0;
    end else begin
      bus.lookup_ack <= cap_pend_q;
      if (cap_pend_q) begin
        bus.lookup_hit  <= bus.cam_match_found;
        bus.lookup_addr <= match_idx;
      end
      if (pop) bus.cam_lookup_data <= fifo_mem[rd_ptr_q];
      if (grant_write) begin
        bus.cam_waddr <= bus.wr_addr;
        bus.cam_wdata <= bus.wr_data;
        bus.cam_wcare <= bus.wr_care;
      end
      if (drop && (bus.drop_count != '1)) bus.drop_count <= bus.drop_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_lpm_cam_arbiter.sv
// Bench for lpm_cam_arbiter: behavioural CAM, lookup scoreboard, vector table
// and hand-written write/reset/arbitration/saturation sequences.
module tb_lpm_cam_arbiter;
  logic clk;
  logic reset;

  lpm_cam_arbiter_if #(.LUT_DEPTH_BITS(5)) bus ();

  lpm_cam_arbiter #(.LUT_DEPTH_BITS(5), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       hit;
    logic [4:0] addr;
  } exp_t;

  typedef struct {
    logic [31:0] key;
    logic [31:0] mask;
    logic        hit;
    logic [4:0]  addr;
  } vec_t;

  int          checks;
  int          failures;
  int          cyc;
  int          n_start;
  int          n_wrack;
  bit          sb_en;
  bit          log_en;
  bit          cam_hold;
  logic [7:0]  busy;
  logic [7:0]  ready_low;
  logic [31:0] cam_lines;
  logic [31:0] prev_lk;
  logic [31:0] cam_map [logic [31:0]];
  exp_t        sb [$];
  int          ack_cyc_q [$];
  logic [7:0]  grant_log [$];
  vec_t        vecs [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural CAM: registered match result, busy for ready_low cycles after a write start.
  assign bus.cam_match_lines = cam_lines;
  assign bus.cam_match_found = |cam_lines;
  assign bus.cam_ready       = (busy == 8'd0) && !cam_hold;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    cam_lines <= cam_map.exists(bus.cam_lookup_data) ? cam_map[bus.cam_lookup_data] : 32'd0;
    if (bus.cam_start_write) busy <= ready_low;
    else if (busy != 8'd0)   busy <= busy - 8'd1;
  end

  // Output monitor and scoreboard pop.
  always @(negedge clk) begin
    if (bus.cam_start_write) n_start <= n_start + 1;
    if (bus.wr_ack)          n_wrack <= n_wrack + 1;
    if (bus.lookup_ack) begin
      ack_cyc_q.push_back(cyc);
      if (sb_en) begin
        check("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("ack_hit", 32'(bus.lookup_hit), 32'(sb[0].hit));
          check("ack_addr", 32'(bus.lookup_addr), 32'(sb[0].addr));
          void'(sb.pop_front());
        end
      end
    end
    if (log_en && (bus.cam_lookup_data != prev_lk)) grant_log.push_back(8'h4C);
    if (log_en && bus.cam_start_write)              grant_log.push_back(8'h57);
    prev_lk <= bus.cam_lookup_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] key, input logic [31:0] mask,
                      input logic hit, input logic [4:0] addr, input bit accept);
    exp_t e;
    cam_map[key]   = mask;
    bus.lookup_req = 1'b1;
    bus.lookup_key = key;
    e.hit  = hit;
    e.addr = addr;
    if (accept) sb.push_back(e);
    step();
    bus.lookup_req = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    step();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    sb.delete();
    reset = 1'b0;
    step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_lookup_ack"}, 32'(bus.lookup_ack), 32'd0);
    check({tag, "_lookup_hit"}, 32'(bus.lookup_hit), 32'd0);
    check({tag, "_lookup_addr"}, 32'(bus.lookup_addr), 32'd0);
    check({tag, "_wr_ack"}, 32'(bus.wr_ack), 32'd0);
    check({tag, "_cam_start_write"}, 32'(bus.cam_start_write), 32'd0);
    check({tag, "_cam_lookup_data"}, bus.cam_lookup_data, 32'd0);
    check({tag, "_cam_waddr"}, 32'(bus.cam_waddr), 32'd0);
    check({tag, "_cam_wdata"}, bus.cam_wdata, 32'd0);
    check({tag, "_cam_wcare"}, bus.cam_wcare, 32'd0);
    check({tag, "_drop_count"}, 32'(bus.drop_count), 32'd0);
    check({tag, "_fifo_full"}, 32'(bus.lookup_fifo_full), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int gap;
    int n0_start;
    int n0_wrack;
    bit found;

    vecs[0] = '{32'h0A00_0001, 32'h0000_0014, 1'b1, 5'd2};
    vecs[1] = '{32'h0A00_0002, 32'h8000_0000, 1'b1, 5'd31};
    vecs[2] = '{32'h0A00_0003, 32'h0000_0001, 1'b1, 5'd0};
    vecs[3] = '{32'h0A00_0004, 32'h0000_0000, 1'b0, 5'd0};
    vecs[4] = '{32'hC0A8_0101, 32'hFFFF_0000, 1'b1, 5'd16};
    vecs[5] = '{32'h0A00_0006, 32'h0000_0300, 1'b1, 5'd8};
    vecs[6] = '{32'h0A00_0007, 32'h0001_0040, 1'b1, 5'd6};
    vecs[7] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 5'd0};

    checks = 0; failures = 0; cyc = 0; n_start = 0; n_wrack = 0;
    sb_en = 1'b1; log_en = 1'b0; cam_hold = 1'b0; busy = 8'd0; ready_low = 8'd10;
    cam_lines = 32'd0; prev_lk = 32'd0;
    bus.lookup_req = 1'b0; bus.lookup_key = 32'd0;
    bus.wr_req = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0; bus.wr_care = 32'd0;

    reset = 1'b1;
    repeat (3) step();
    check_reset("rst0");
    reset = 1'b0;
    step();

    // Single lookup: latency of three edges after the sampling edge.
    send(vecs[0].key, vecs[0].mask, vecs[0].hit, vecs[0].addr, 1'b1);
    lat = 0;
    while (!bus.lookup_ack && lat < 10) begin
      step();
      lat++;
    end
    check("lookup_latency", 32'(lat), 32'd3);
    drain("drain_v0", 10);

    // Vector table, one lookup at a time.
    for (int i = 1; i < 8; i++) begin
      send(vecs[i].key, vecs[i].mask, vecs[i].hit, vecs[i].addr, 1'b1);
      drain("drain_vec", 20);
    end

    // Back-to-back lookups: one result every two cycles.
    ack_cyc_q.delete();
    for (int i = 1; i < 5; i++) send(vecs[i].key, vecs[i].mask, vecs[i].hit, vecs[i].addr, 1'b1);
    drain("drain_burst", 30);
    check("burst_ack_count", 32'(ack_cyc_q.size()), 32'd4);
    gap = (ack_cyc_q.size() == 4) ? ack_cyc_q[3] - ack_cyc_q[0] : 0;
    check("burst_ack_span", 32'(gap), 32'd6);

    // Write with a long CAM busy period; six lookups arrive meanwhile.
    n0_start = n_start; n0_wrack = n_wrack; ready_low = 8'd10;
    bus.wr_addr = 5'd7; bus.wr_data = 32'h0A0B_0C0D; bus.wr_care = 32'hFFFF_FF00; bus.wr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = bus.cam_start_write;
    end
    check("wr_start_seen", 32'(found), 32'd1);
    check("cam_waddr", 32'(bus.cam_waddr), 32'd7);
    check("cam_wdata", bus.cam_wdata, 32'h0A0B_0C0D);
    check("cam_wcare", bus.cam_wcare, 32'hFFFF_FF00);
    bus.wr_addr = 5'd3; bus.wr_data = 32'd0; bus.wr_care = 32'd0;
    for (int i = 0; i < 6; i++)
      send(32'h0B00_0000 + 32'(i), 32'd1 << (i + 1), 1'b1, 5'(i + 1), i < 4);
    check("drop_count_burst", 32'(bus.drop_count), 32'd2);
    check("fifo_full_burst", 32'(bus.lookup_fifo_full), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = bus.wr_ack;
    end
    check("wr_ack_seen", 32'(found), 32'd1);
    check("cam_waddr_stable", 32'(bus.cam_waddr), 32'd7);
    check("cam_wdata_stable", bus.cam_wdata, 32'h0A0B_0C0D);
    step();
    bus.wr_req = 1'b0;
    drain("drain_after_write", 40);
    check("write_start_pulses", 32'(n_start - n0_start), 32'd1);
    check("write_ack_pulses", 32'(n_wrack - n0_wrack), 32'd1);

    // Reset in WR_WAIT with the CAM busy: write abandoned, no grant until ready.
    n0_wrack = n_wrack;
    bus.wr_addr = 5'd5; bus.wr_data = 32'h1122_3344; bus.wr_care = 32'hFFFF_FFFF; bus.wr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = bus.cam_start_write;
    end
    check("wr2_start_seen", 32'(found), 32'd1);
    cam_hold = 1'b1;
    send(32'h0C00_0001, 32'h0000_0001, 1'b1, 5'd0, 1'b0);
    step();
    reset = 1'b1;
    #1;
    check_reset("rst_mid_write");
    bus.wr_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    send(32'h0C00_0002, 32'h0000_0100, 1'b1, 5'd8, 1'b1);
    repeat (5) step();
    check("no_grant_while_busy", bus.cam_lookup_data, 32'd0);
    check("lookup_pending", 32'(sb.size()), 32'd1);
    check("no_wr_ack_across_reset", 32'(n_wrack), 32'(n0_wrack));
    cam_hold = 1'b0;
    drain("drain_after_reset", 30);
    check("granted_after_ready", bus.cam_lookup_data, 32'h0C00_0002);

    // Contended arbitration: lookups and writes must alternate.
    do_reset();
    sb_en = 1'b0; ready_low = 8'd2; grant_log.delete(); log_en = 1'b1;
    bus.lookup_req = 1'b1; bus.lookup_key = 32'h2000_0000;
    step();
    bus.wr_req = 1'b1;
    for (int i = 1; i < 80 && grant_log.size() < 6; i++) begin
      bus.lookup_key = 32'h2000_0000 + 32'(i);
      step();
    end
    bus.lookup_req = 1'b0; bus.wr_req = 1'b0; log_en = 1'b0;
    for (int k = 0; k < 6; k++)
      check("grant_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'd0,
            (k % 2 == 0) ? 32'h4C : 32'h57);

    // Drop counter saturation with the CAM held busy.
    do_reset();
    cam_hold = 1'b1;
    bus.lookup_req = 1'b1; bus.lookup_key = 32'h3000_0000;
    repeat (4 + 65534) step();
    check("drop_count_fffe", 32'(bus.drop_count), 32'h0000_FFFE);
    step();
    check("drop_count_ffff", 32'(bus.drop_count), 32'h0000_FFFF);
    repeat (5) step();
    check("drop_count_saturated", 32'(bus.drop_count), 32'h0000_FFFF);
    check("fifo_full_saturated", 32'(bus.lookup_fifo_full), 32'd1);
    bus.lookup_req = 1'b0;
    do_reset();
    cam_hold = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
